// File: rtl/mod_exp_pkg.sv
// Shared definitions for the streaming modular exponentiator: default sizes,
// FSM state encoding and the modular multiplier cycle budget.
package mod_exp_pkg;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_WORDS      = 4;

    // Start cycle and capture cycle wrap around the per-bit iterations.
    localparam int MUL_OVERHEAD_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_CHECK = 3'd1,
        ST_SQR   = 3'd2,
        ST_MUL   = 3'd3,
        ST_NEXT  = 3'd4,
        ST_OUT   = 3'd5
    } state_t;

    function automatic int mulCycles(input int opW);
        return opW + MUL_OVERHEAD_CYCLES;
    endfunction

endpackage

// File: rtl/mod_mul_serial.sv
// Bit-serial interleaved modular multiplier: p = a*b mod n, MSB of a first.
// Requires b < n; one start cycle, OP_W iteration cycles, one capture cycle.
module mod_mul_serial
    import mod_exp_pkg::*;
#(
    parameter int OP_W = 256
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    input  logic [OP_W-1:0] n,
    output logic            done,
    output logic [OP_W-1:0] p
);

    localparam int CYC = mulCycles(OP_W);
    localparam int CW  = $clog2(CYC + 1);
    localparam int EW  = OP_W + 2;

    logic            r_active;
    logic [CW-1:0]   r_cnt;
    logic [OP_W-1:0] r_a;
    logic [EW-1:0]   r_b;
    logic [EW-1:0]   r_n;
    logic [EW-1:0]   r_p;

    logic [EW-1:0]   w_dbl;
    logic [EW-1:0]   w_dblRed;
    logic [EW-1:0]   w_sum;
    logic [EW-1:0]   w_sumRed;

    // P < n and b < n keep each stage below 2n, so one subtraction per stage suffices.
    always_comb begin
        w_dbl    = r_p << 1;
        w_dblRed = (w_dbl >= r_n) ? (w_dbl - r_n) : w_dbl;
        w_sum    = r_a[OP_W-1] ? (w_dblRed + r_b) : w_dblRed;
        w_sumRed = (w_sum >= r_n) ? (w_sum - r_n) : w_sum;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_n      <= '0;
            r_p      <= '0;
        end else if (start && !r_active) begin
            r_active <= 1'b1;
            r_cnt    <= CW'(1);
            r_a      <= a;
            r_b      <= {2'b00, b};
            r_n      <= {2'b00, n};
            r_p      <= '0;
        end else if (r_active) begin
            if (r_cnt == CW'(CYC - 1)) begin
                r_active <= 1'b0;
            end else begin
                r_p   <= w_sumRed;
                r_a   <= r_a << 1;
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign done = r_active && (r_cnt == CW'(CYC - 1));
    assign p    = r_p[OP_W-1:0];

endmodule

// File: rtl/mod_exp_stream.sv
// Streaming modular exponentiator m^e mod n using left-to-right square-and-multiply.
// Define MOD_EXP_CONST_TIME_EN to run the multiply step for every exponent bit.
module mod_exp_stream
    import mod_exp_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int WORDS      = DEF_WORDS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_err,
    output logic                  busy,
    output logic [2:0]            state
);

    localparam int OP_W = DATA_WIDTH * WORDS;
    localparam int IDXW = (OP_W > 1) ? $clog2(OP_W) : 1;
    localparam int WCW  = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_t                r_state;
    logic                  r_inReady;
    logic                  r_outValid;
    logic                  r_outErr;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_outData;
    logic [OP_W-1:0]       r_n;
    logic [OP_W-1:0]       r_m;
    logic [OP_W-1:0]       r_e;
    logic [OP_W-1:0]       r_r;
    logic [OP_W-1:0]       r_res;
    logic [IDXW-1:0]       r_idx;
    logic [WCW-1:0]        r_wordCnt;
    logic [1:0]            r_opSel;
    logic                  r_mulStarted;

    logic                  w_inFire;
    logic                  w_outFire;
    logic                  w_lastWord;
    logic                  w_ebit;
    logic                  w_mulStart;
    logic                  w_mulDone;
    logic [OP_W-1:0]       w_mulB;
    logic [OP_W-1:0]       w_mulP;
    logic [OP_W-1:0]       w_resShift;

    assign w_inFire   = in_valid && r_inReady;
    assign w_outFire  = r_outValid && out_ready;
    assign w_lastWord = (r_wordCnt == WCW'(WORDS - 1));
    assign w_ebit     = r_e[r_idx];
    assign w_mulStart = ((r_state == ST_SQR) || (r_state == ST_MUL)) && !r_mulStarted;
    assign w_mulB     = (r_state == ST_MUL) ? r_m : r_r;
    assign w_resShift = r_res >> DATA_WIDTH;

    mod_mul_serial #(
        .OP_W (OP_W)
    ) u_mul (
        .clk   (clk),
        .reset (reset),
        .start (w_mulStart),
        .a     (r_r),
        .b     (w_mulB),
        .n     (r_n),
        .done  (w_mulDone),
        .p     (w_mulP)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_LOAD;
            r_inReady    <= 1'b1;
            r_outValid   <= 1'b0;
            r_outErr     <= 1'b0;
            r_busy       <= 1'b0;
            r_outData    <= '0;
            r_n          <= '0;
            r_m          <= '0;
            r_e          <= '0;
            r_r          <= '0;
            r_res        <= '0;
            r_idx        <= '0;
            r_wordCnt    <= '0;
            r_opSel      <= '0;
            r_mulStarted <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_inFire) begin
                        r_busy <= 1'b1;
                        case (r_opSel)
                            2'd0:    r_n[int'(r_wordCnt)*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                            2'd1:    r_m[int'(r_wordCnt)*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                            default: r_e[int'(r_wordCnt)*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                        endcase
                        if (w_lastWord) begin
                            r_wordCnt <= '0;
                            if (r_opSel == 2'd2) begin
                                r_opSel   <= '0;
                                r_inReady <= 1'b0;
                                r_state   <= ST_CHECK;
                            end else begin
                                r_opSel <= r_opSel + 2'd1;
                            end
                        end else begin
                            r_wordCnt <= r_wordCnt + WCW'(1);
                        end
                    end
                end

                ST_CHECK: begin
                    if ((r_n == '0) || (r_m >= r_n)) begin
                        r_outErr   <= 1'b1;
                        r_res      <= '0;
                        r_outData  <= '0;
                        r_outValid <= 1'b1;
                        r_state    <= ST_OUT;
                    end else begin
                        r_r     <= (r_n == OP_W'(1)) ? '0 : OP_W'(1);
                        r_idx   <= IDXW'(OP_W - 1);
                        r_state <= ST_SQR;
                    end
                end

                // The first cycle in SQR/MUL launches the multiplier; done marks the capture cycle.
                ST_SQR: begin
                    if (!r_mulStarted) begin
                        r_mulStarted <= 1'b1;
                    end else if (w_mulDone) begin
                        r_mulStarted <= 1'b0;
                        r_r          <= w_mulP;
`ifdef MOD_EXP_CONST_TIME_EN
                        r_state      <= ST_MUL;
`else
                        r_state      <= w_ebit ? ST_MUL : ST_NEXT;
`endif
                    end
                end

                ST_MUL: begin
                    if (!r_mulStarted) begin
                        r_mulStarted <= 1'b1;
                    end else if (w_mulDone) begin
                        r_mulStarted <= 1'b0;
`ifdef MOD_EXP_CONST_TIME_EN
                        if (w_ebit) begin
                            r_r <= w_mulP;
                        end
`else
                        r_r <= w_mulP;
`endif
                        r_state <= ST_NEXT;
                    end
                end

                ST_NEXT: begin
                    if (r_idx == '0) begin
                        r_res      <= r_r;
                        r_outData  <= r_r[DATA_WIDTH-1:0];
                        r_outValid <= 1'b1;
                        r_state    <= ST_OUT;
                    end else begin
                        r_idx   <= r_idx - IDXW'(1);
                        r_state <= ST_SQR;
                    end
                end

                ST_OUT: begin
                    if (w_outFire) begin
                        if (w_lastWord) begin
                            r_wordCnt  <= '0;
                            r_res      <= '0;
                            r_outData  <= '0;
                            r_outValid <= 1'b0;
                            r_outErr   <= 1'b0;
                            r_busy     <= 1'b0;
                            r_inReady  <= 1'b1;
                            r_state    <= ST_LOAD;
                        end else begin
                            r_wordCnt <= r_wordCnt + WCW'(1);
                            r_res     <= w_resShift;
                            r_outData <= w_resShift[DATA_WIDTH-1:0];
                        end
                    end
                end

                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

    assign in_ready  = r_inReady;
    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign out_err   = r_outErr;
    assign busy      = r_busy;
    assign state     = r_state;

endmodule

// File: tb/tb_mod_exp_stream.sv
// Directed bench for mod_exp_stream at 8-bit beats with one-word and two-word operands;
// a reference model fills a scoreboard that is drained as result beats are accepted.
`timescale 1ns/1ps
module tb_mod_exp_stream;

    logic       clk;
    logic       reset;
    logic       inValid  [2];
    logic       inReady  [2];
    logic [7:0] inData   [2];
    logic       outValid [2];
    logic       outReady [2];
    logic [7:0] outData  [2];
    logic       outErr   [2];
    logic       busy     [2];
    logic [2:0] st       [2];

    int         nPass  = 0;
    int         nTotal = 0;
    logic [8:0] sbq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mod_exp_stream #(.DATA_WIDTH(8), .WORDS(1)) u0 (
        .clk(clk), .reset(reset), .in_valid(inValid[0]), .in_ready(inReady[0]),
        .in_data(inData[0]), .out_valid(outValid[0]), .out_ready(outReady[0]),
        .out_data(outData[0]), .out_err(outErr[0]), .busy(busy[0]), .state(st[0])
    );

    mod_exp_stream #(.DATA_WIDTH(8), .WORDS(2)) u1 (
        .clk(clk), .reset(reset), .in_valid(inValid[1]), .in_ready(inReady[1]),
        .in_data(inData[1]), .out_valid(outValid[1]), .out_ready(outReady[1]),
        .out_data(outData[1]), .out_err(outErr[1]), .busy(busy[1]), .state(st[1])
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nTotal++;
        assert (obs === exp) nPass++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: plain repeated multiplication, {err, result}.
    function automatic logic [16:0] modelExp(input int n, input int m, input int e);
        longint r;
        if ((n == 0) || (m >= n)) return {1'b1, 16'h0000};
        r = 1 % n;
        for (int i = 0; i < e; i++) r = (r * m) % n;
        return {1'b0, 16'(r)};
    endfunction

    function automatic int expLatency(input int words, input int e);
        int opw = 8 * words;
        int pc  = 0;
        for (int i = 0; i < opw; i++) pc += (e >> i) & 1;
`ifdef MOD_EXP_CONST_TIME_EN
        pc = 0;
        return 1 + opw * (2 * opw + 5) + pc;
`else
        return 1 + opw * (opw + 3) + pc * (opw + 2);
`endif
    endfunction

    task automatic applyStimulus(input int u, input logic [15:0] n, input logic [15:0] m,
                                 input logic [15:0] e);
        int          words = (u == 0) ? 1 : 2;
        logic [16:0] r     = modelExp(int'(n), int'(m), int'(e));
        logic [7:0]  beats [6];
        logic [15:0] ops   [3];
        ops[0] = n; ops[1] = m; ops[2] = e;
        for (int k = 0; k < 3; k++)
            for (int w = 0; w < words; w++)
                beats[k*words + w] = 8'(ops[k] >> (8 * w));
        for (int w = 0; w < words; w++)
            sbq.push_back({r[16], 8'(r[15:0] >> (8 * w))});
        for (int b = 0; b < 3 * words; b++) begin
            @(negedge clk);
            inValid[u] = 1'b1;
            inData[u]  = beats[b];
            checkOutput("in_ready_load", inReady[u], 1);
            @(posedge clk);
            #1;
            if (b == 0) checkOutput("busy_after_first", busy[u], 1);
        end
        inValid[u] = 1'b0;
    endtask

    task automatic collectOutput(input int u, input int hold, input int expLat, input bit checkLat);
        int          words = (u == 0) ? 1 : 2;
        int          lat   = 0;
        logic        got   = 1'b0;
        logic        stable;
        logic [7:0]  held;
        logic [8:0]  exp;
        while (!got && lat < 3000) begin
            @(posedge clk);
            #1;
            lat++;
            if (outValid[u] === 1'b1) got = 1'b1;
        end
        checkOutput("out_valid_seen", got, 1);
        if (checkLat) checkOutput("latency", lat, expLat);
        checkOutput("in_ready_busy", inReady[u], 0);
        for (int w = 0; w < words; w++) begin
            if (hold > 0) begin
                held   = outData[u];
                stable = 1'b1;
                repeat (hold) begin
                    @(posedge clk);
                    #1;
                    if ((outData[u] !== held) || (outValid[u] !== 1'b1)) stable = 1'b0;
                end
                checkOutput("hold_stable", stable, 1);
            end
            @(negedge clk);
            outReady[u] = 1'b1;
            checkOutput("sb_nonempty", sbq.size() > 0, 1);
            exp = (sbq.size() > 0) ? sbq.pop_front() : 9'h1FF;
            checkOutput("out_data", outData[u], exp[7:0]);
            checkOutput("out_err", outErr[u], exp[8]);
            checkOutput("out_valid_beat", outValid[u], 1);
            @(posedge clk);
            #1;
            outReady[u] = 1'b0;
        end
        checkOutput("busy_done", busy[u], 0);
        checkOutput("state_load", st[u], 0);
        checkOutput("out_valid_done", outValid[u], 0);
    endtask

    task automatic checkResetValues(input int u);
        checkOutput("rst_state", st[u], 0);
        checkOutput("rst_in_ready", inReady[u], 1);
        checkOutput("rst_out_valid", outValid[u], 0);
        checkOutput("rst_out_data", outData[u], 0);
        checkOutput("rst_out_err", outErr[u], 0);
        checkOutput("rst_busy", busy[u], 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int guard;
        reset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            inValid[u]  = 1'b0;
            inData[u]   = 8'h00;
            outReady[u] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        checkResetValues(0);
        checkResetValues(1);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] basic exponentiation, one and two word operands");
        applyStimulus(0, 16'hDD, 16'h05, 16'h03);
        collectOutput(0, 0, expLatency(1, 3), 1'b1);
        applyStimulus(1, 16'h03E8, 16'h0002, 16'h000A);
        collectOutput(1, 0, expLatency(2, 16'h000A), 1'b1);

        $display("[TB] error and edge operands");
        applyStimulus(0, 16'hDD, 16'hE0, 16'h03);
        collectOutput(0, 0, 0, 1'b0);
        applyStimulus(0, 16'h00, 16'h05, 16'h03);
        collectOutput(0, 0, 0, 1'b0);
        applyStimulus(0, 16'hDD, 16'h05, 16'h00);
        collectOutput(0, 0, expLatency(1, 0), 1'b1);
        applyStimulus(0, 16'h01, 16'h00, 16'h05);
        collectOutput(0, 0, expLatency(1, 5), 1'b1);

        $display("[TB] output backpressure");
        applyStimulus(1, 16'h03E8, 16'h0002, 16'h000A);
        collectOutput(1, 20, 0, 1'b0);
        applyStimulus(0, 16'hDD, 16'h05, 16'h03);
        collectOutput(0, 20, 0, 1'b0);

        $display("[TB] reset during squaring");
        applyStimulus(0, 16'hDD, 16'h05, 16'h03);
        guard = 0;
        while ((st[0] !== 3'd2) && (guard < 50)) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkOutput("reached_sqr", st[0], 2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkResetValues(0);
        @(negedge clk);
        reset = 1'b0;
        sbq.delete();
        applyStimulus(0, 16'hDD, 16'h05, 16'h03);
        collectOutput(0, 0, expLatency(1, 3), 1'b1);

        $display("[TB] exponent extremes");
        applyStimulus(0, 16'hDD, 16'h05, 16'h01);
        collectOutput(0, 0, expLatency(1, 16'h01), 1'b1);
        applyStimulus(0, 16'hDD, 16'h05, 16'hFF);
        collectOutput(0, 0, expLatency(1, 16'hFF), 1'b1);

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
